// File: rtl/rs_alu_pkg.sv
// ALU reservation station shared types, widths and the operand snoop helper.
// Tag value tagFree marks an operand whose value is already present.
package rs_alu_pkg;

  localparam int dataWidth    = 32;
  localparam int addrWidth    = 32;
  localparam int tagWidth     = 6;
  localparam int newopWidth   = 4;
  localparam int RS_ALU_DEPTH = 8;

  localparam logic [tagWidth-1:0] tagFree = '0;

  typedef enum logic [newopWidth-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_JAL  = 4'd10,
    OP_JALR = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [dataWidth-1:0] val;
    logic [tagWidth-1:0]  tag;
  } opnd_t;

  typedef struct packed {
    logic [newopWidth-1:0] op;
    logic [addrWidth-1:0]  pc;
    logic [tagWidth-1:0]   dest;
    opnd_t                 s1;
    opnd_t                 s2;
  } rs_entry_t;

  // cdb0 is checked first so it wins if both buses carry the same tag
  function automatic opnd_t snoop(
    input opnd_t                o,
    input logic                 c0_en,
    input logic [tagWidth-1:0]  c0_tag,
    input logic [dataWidth-1:0] c0_data,
    input logic                 c1_en,
    input logic [tagWidth-1:0]  c1_tag,
    input logic [dataWidth-1:0] c1_data
  );
    opnd_t r;
    r = o;
    if (o.tag != tagFree) begin
      if (c0_en && (o.tag == c0_tag)) begin
        r.val = c0_data;
        r.tag = tagFree;
      end else if (c1_en && (o.tag == c1_tag)) begin
        r.val = c1_data;
        r.tag = tagFree;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_alu_prio_enc.sv
// Lowest-index-set finder: reports whether any bit is set and
// the index of the lowest one.
module rs_alu_prio_enc #(
  parameter int N   = 8,
  parameter int IDX = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  output logic           vld_o,
  output logic [IDX-1:0] idx_o
);

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        vld_o = 1'b1;
        idx_o = IDX'(i);
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops until both operands
// are valid, snoops two CDBs, issues one ready op per cycle.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_DEPTH = RS_ALU_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  disp_en,
  input  logic [newopWidth-1:0] disp_op,
  input  logic [addrWidth-1:0]  disp_pc,
  input  logic [tagWidth-1:0]   disp_dest,
  input  logic [dataWidth-1:0]  disp_src1,
  input  logic [dataWidth-1:0]  disp_src2,
  input  logic [tagWidth-1:0]   disp_tag1,
  input  logic [tagWidth-1:0]   disp_tag2,
  input  logic                  cdb0_en,
  input  logic [tagWidth-1:0]   cdb0_tag,
  input  logic [dataWidth-1:0]  cdb0_data,
  input  logic                  cdb1_en,
  input  logic [tagWidth-1:0]   cdb1_tag,
  input  logic [dataWidth-1:0]  cdb1_data,
  output logic                  rs_full,
  output logic                  ex_alu_en,
  output logic [dataWidth-1:0]  exsrc1,
  output logic [dataWidth-1:0]  exsrc2,
  output logic [addrWidth-1:0]  expc,
  output logic [newopWidth-1:0] exaluop,
  output logic [tagWidth-1:0]   exdest
);

  localparam int IDX = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0] valid_q, valid_d, rdy;
  rs_entry_t ent_q [RS_DEPTH];
  rs_entry_t ent_d [RS_DEPTH];
  rs_entry_t ent_w [RS_DEPTH];
  rs_entry_t disp_ent;

  logic           free_vld, sel_vld;
  logic [IDX-1:0] free_idx, sel_idx;

  logic                  en_q;
  logic [dataWidth-1:0]  src1_q, src2_q;
  logic [addrWidth-1:0]  pc_q;
  logic [newopWidth-1:0] op_q;
  logic [tagWidth-1:0]   dest_q;

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_wake
    assign ent_w[g] = '{
      op:   ent_q[g].op,
      pc:   ent_q[g].pc,
      dest: ent_q[g].dest,
      s1:   snoop(ent_q[g].s1,
                  cdb0_en, cdb0_tag, cdb0_data,
                  cdb1_en, cdb1_tag, cdb1_data),
      s2:   snoop(ent_q[g].s2,
                  cdb0_en, cdb0_tag, cdb0_data,
                  cdb1_en, cdb1_tag, cdb1_data)
    };
    assign rdy[g] = valid_q[g]
                  & (ent_q[g].s1.tag == tagFree)
                  & (ent_q[g].s2.tag == tagFree);
  end

  // Same-cycle CDB hit on a dispatching tag must not be lost
  assign disp_ent = '{
    op:   disp_op,
    pc:   disp_pc,
    dest: disp_dest,
    s1:   snoop('{val: disp_src1, tag: disp_tag1},
                cdb0_en, cdb0_tag, cdb0_data,
                cdb1_en, cdb1_tag, cdb1_data),
    s2:   snoop('{val: disp_src2, tag: disp_tag2},
                cdb0_en, cdb0_tag, cdb0_data,
                cdb1_en, cdb1_tag, cdb1_data)
  };

  rs_alu_prio_enc #(.N(RS_DEPTH), .IDX(IDX)) u_free (
    .req_i (~valid_q),
    .vld_o (free_vld),
    .idx_o (free_idx)
  );

  rs_alu_prio_enc #(.N(RS_DEPTH), .IDX(IDX)) u_sel (
    .req_i (rdy),
    .vld_o (sel_vld),
    .idx_o (sel_idx)
  );

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_w;
    if (sel_vld) begin
      valid_d[sel_idx] = 1'b0;
    end
    if (disp_en && free_vld) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx]   = disp_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      en_q   <= 1'b0;
      src1_q <= '0;
      src2_q <= '0;
      pc_q   <= '0;
      op_q   <= '0;
      dest_q <= tagFree;
    end else if (flush) begin
      valid_q <= '0;
      en_q    <= 1'b0;
      dest_q  <= tagFree;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      en_q <= sel_vld;
      if (sel_vld) begin
        src1_q <= ent_q[sel_idx].s1.val;
        src2_q <= ent_q[sel_idx].s2.val;
        pc_q   <= ent_q[sel_idx].pc;
        op_q   <= ent_q[sel_idx].op;
        dest_q <= ent_q[sel_idx].dest;
      end
    end
  end

  assign rs_full   = &valid_q;
  assign ex_alu_en = en_q;
  assign exsrc1    = src1_q;
  assign exsrc2    = src2_q;
  assign expc      = pc_q;
  assign exaluop   = op_q;
  assign exdest    = dest_q;

`ifndef SYNTHESIS
  a_no_disp_when_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(disp_en && rs_full && !flush)
  );
`endif

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios plus a
// randomized run against a slot-array reference model.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush;
  logic                  disp_en;
  logic [newopWidth-1:0] disp_op;
  logic [addrWidth-1:0]  disp_pc;
  logic [tagWidth-1:0]   disp_dest;
  logic [dataWidth-1:0]  disp_src1, disp_src2;
  logic [tagWidth-1:0]   disp_tag1, disp_tag2;
  logic                  cdb0_en, cdb1_en;
  logic [tagWidth-1:0]   cdb0_tag, cdb1_tag;
  logic [dataWidth-1:0]  cdb0_data, cdb1_data;
  logic                  rs_full, ex_alu_en;
  logic [dataWidth-1:0]  exsrc1, exsrc2;
  logic [addrWidth-1:0]  expc;
  logic [newopWidth-1:0] exaluop;
  logic [tagWidth-1:0]   exdest;

  int n_cmp = 0;
  int n_err = 0;

  rs_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .disp_en   (disp_en),
    .disp_op   (disp_op),
    .disp_pc   (disp_pc),
    .disp_dest (disp_dest),
    .disp_src1 (disp_src1),
    .disp_src2 (disp_src2),
    .disp_tag1 (disp_tag1),
    .disp_tag2 (disp_tag2),
    .cdb0_en   (cdb0_en),
    .cdb0_tag  (cdb0_tag),
    .cdb0_data (cdb0_data),
    .cdb1_en   (cdb1_en),
    .cdb1_tag  (cdb1_tag),
    .cdb1_data (cdb1_data),
    .rs_full   (rs_full),
    .ex_alu_en (ex_alu_en),
    .exsrc1    (exsrc1),
    .exsrc2    (exsrc2),
    .expc      (expc),
    .exaluop   (exaluop),
    .exdest    (exdest)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush     = 1'b0;
    disp_en   = 1'b0;
    disp_op   = '0;
    disp_pc   = '0;
    disp_dest = '0;
    disp_src1 = '0;
    disp_src2 = '0;
    disp_tag1 = tagFree;
    disp_tag2 = tagFree;
    cdb0_en   = 1'b0;
    cdb0_tag  = '0;
    cdb0_data = '0;
    cdb1_en   = 1'b0;
    cdb1_tag  = '0;
    cdb1_data = '0;
  endtask

  task automatic disp(
    input logic [3:0]  op,
    input logic [31:0] pc,
    input logic [5:0]  dest,
    input logic [31:0] s1,
    input logic [5:0]  t1,
    input logic [31:0] s2,
    input logic [5:0]  t2
  );
    disp_en   = 1'b1;
    disp_op   = op;
    disp_pc   = pc;
    disp_dest = dest;
    disp_src1 = s1;
    disp_tag1 = t1;
    disp_src2 = s2;
    disp_tag2 = t2;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({ex_alu_en, exsrc1, exsrc2, expc, exaluop, exdest, rs_full}
        !== {1'b0, 32'd0, 32'd0, 32'd0, 4'd0, tagFree, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: en=%0b s1=%h s2=%h pc=%h op=%h dest=%h full=%0b, want all zero",
               ex_alu_en, exsrc1, exsrc2, expc, exaluop, exdest, rs_full);
    end
  endtask

  task automatic test_ready_dispatch();
    disp(4'd0, 32'h100, 6'd20, 32'd5, tagFree, 32'd7, tagFree);
    tick();
    idle();
    n_cmp++;
    if (ex_alu_en !== 1'b0 || rs_full !== 1'b0) begin
      n_err++;
      $display("FAIL t1_early: en=%0b full=%0b want 0 0", ex_alu_en, rs_full);
    end
    tick();
    n_cmp++;
    if ({ex_alu_en, exsrc1, exsrc2, expc, exaluop, exdest, rs_full}
        !== {1'b1, 32'd5, 32'd7, 32'h100, 4'd0, 6'd20, 1'b0}) begin
      n_err++;
      $display("FAIL t1_issue: en=%0b s1=%0d s2=%0d pc=%h dest=%0d full=%0b want 1 5 7 100 20 0",
               ex_alu_en, exsrc1, exsrc2, expc, exdest, rs_full);
    end
    tick();
    n_cmp++;
    if (ex_alu_en !== 1'b0) begin
      n_err++;
      $display("FAIL t1_single: en=%0b want 0", ex_alu_en);
    end
  endtask

  task automatic test_cdb1_wakeup();
    disp(4'd1, 32'h200, 6'd21, 32'd0, 6'd3, 32'd9, tagFree);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (ex_alu_en !== 1'b0) begin
        n_err++;
        $display("FAIL t2_wait%0d: en=%0b want 0", i, ex_alu_en);
      end
    end
    cdb1_en   = 1'b1;
    cdb1_tag  = 6'd3;
    cdb1_data = 32'hDEAD;
    tick();
    idle();
    n_cmp++;
    if (ex_alu_en !== 1'b0) begin
      n_err++;
      $display("FAIL t2_bypass: en=%0b want 0", ex_alu_en);
    end
    tick();
    n_cmp++;
    if ({ex_alu_en, exsrc1, exsrc2, exdest}
        !== {1'b1, 32'hDEAD, 32'd9, 6'd21}) begin
      n_err++;
      $display("FAIL t2_issue: en=%0b s1=%h s2=%0d dest=%0d want 1 dead 9 21",
               ex_alu_en, exsrc1, exsrc2, exdest);
    end
    tick();
  endtask

  task automatic test_same_cycle_cdb();
    disp(4'd2, 32'h300, 6'd22, 32'd1, tagFree, 32'd0, 6'd9);
    cdb0_en   = 1'b1;
    cdb0_tag  = 6'd9;
    cdb0_data = 32'h10;
    tick();
    idle();
    tick();
    n_cmp++;
    if ({ex_alu_en, exsrc1, exsrc2, exdest}
        !== {1'b1, 32'd1, 32'h10, 6'd22}) begin
      n_err++;
      $display("FAIL t3_issue: en=%0b s1=%h s2=%h dest=%0d want 1 1 10 22",
               ex_alu_en, exsrc1, exsrc2, exdest);
    end
    tick();
  endtask

  task automatic test_full_and_order();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rs_full !== 1'b0) begin
        n_err++;
        $display("FAIL t4_notfull%0d: full=%0b want 0", i, rs_full);
      end
      disp(4'(i), 32'h400 + 32'(i), 6'(32 + i),
           32'd0, 6'(10 + i), 32'(i), tagFree);
      tick();
    end
    idle();
    n_cmp++;
    if (rs_full !== 1'b1 || ex_alu_en !== 1'b0) begin
      n_err++;
      $display("FAIL t4_full: full=%0b en=%0b want 1 0", rs_full, ex_alu_en);
    end
    cdb0_en   = 1'b1;
    cdb0_tag  = 6'd15;
    cdb0_data = 32'h55;
    tick();
    idle();
    n_cmp++;
    if (rs_full !== 1'b1 || ex_alu_en !== 1'b0) begin
      n_err++;
      $display("FAIL t4_wake5: full=%0b en=%0b want 1 0", rs_full, ex_alu_en);
    end
    tick();
    n_cmp++;
    if ({ex_alu_en, exsrc1, exsrc2, exdest, rs_full}
        !== {1'b1, 32'h55, 32'd5, 6'd37, 1'b0}) begin
      n_err++;
      $display("FAIL t4_issue5: en=%0b s1=%h s2=%0d dest=%0d full=%0b want 1 55 5 37 0",
               ex_alu_en, exsrc1, exsrc2, exdest, rs_full);
    end
    cdb0_en   = 1'b1;
    cdb0_tag  = 6'd12;
    cdb0_data = 32'h22;
    cdb1_en   = 1'b1;
    cdb1_tag  = 6'd16;
    cdb1_data = 32'h66;
    tick();
    idle();
    n_cmp++;
    if (ex_alu_en !== 1'b0) begin
      n_err++;
      $display("FAIL t4_gap: en=%0b want 0", ex_alu_en);
    end
    tick();
    n_cmp++;
    if ({ex_alu_en, exsrc1, exdest} !== {1'b1, 32'h22, 6'd34}) begin
      n_err++;
      $display("FAIL t4_first2: en=%0b s1=%h dest=%0d want 1 22 34",
               ex_alu_en, exsrc1, exdest);
    end
    tick();
    n_cmp++;
    if ({ex_alu_en, exsrc1, exdest} !== {1'b1, 32'h66, 6'd38}) begin
      n_err++;
      $display("FAIL t4_then6: en=%0b s1=%h dest=%0d want 1 66 38",
               ex_alu_en, exsrc1, exdest);
    end
    flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      disp(4'd3, 32'h500, 6'(40 + i), 32'd0, 6'(20 + i), 32'd0, tagFree);
      tick();
    end
    disp(4'd4, 32'h600, 6'd50, 32'd1, tagFree, 32'd2, tagFree);
    flush = 1'b1;
    tick();
    idle();
    n_cmp++;
    if ({ex_alu_en, rs_full, exdest} !== {1'b0, 1'b0, tagFree}) begin
      n_err++;
      $display("FAIL t5_flush: en=%0b full=%0b dest=%0d want 0 0 0",
               ex_alu_en, rs_full, exdest);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        cdb0_en   = 1'b1;
        cdb0_tag  = 6'(20 + i);
        cdb0_data = 32'h77;
      end else begin
        idle();
      end
      tick();
      n_cmp++;
      if (ex_alu_en !== 1'b0) begin
        n_err++;
        $display("FAIL t5_stale%0d: en=%0b want 0", i, ex_alu_en);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    disp(4'd5, 32'h700, 6'd44, 32'd1, tagFree, 32'd2, tagFree);
    tick();
    idle();
    tick();
    n_cmp++;
    if (ex_alu_en !== 1'b1) begin
      n_err++;
      $display("FAIL t6_pre: en=%0b want 1", ex_alu_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ex_alu_en, exsrc1, exsrc2, expc, exaluop, exdest, rs_full}
        !== {1'b0, 32'd0, 32'd0, 32'd0, 4'd0, tagFree, 1'b0}) begin
      n_err++;
      $display("FAIL t6_async: en=%0b s1=%h s2=%h pc=%h dest=%h want zeros",
               ex_alu_en, exsrc1, exsrc2, expc, exdest);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  logic        m_v  [8];
  logic [3:0]  m_op [8];
  logic [31:0] m_pc [8];
  logic [5:0]  m_dst[8];
  logic [31:0] m_s1 [8];
  logic [5:0]  m_t1 [8];
  logic [31:0] m_s2 [8];
  logic [5:0]  m_t2 [8];
  logic        e_en;
  logic [31:0] e_s1, e_s2, e_pc;
  logic [3:0]  e_op;
  logic [5:0]  e_dst;

  function automatic logic [37:0] wake(input logic [31:0] v,
                                       input logic [5:0] t);
    if (t == tagFree) return {v, t};
    if (cdb0_en && cdb0_tag == t) return {cdb0_data, tagFree};
    if (cdb1_en && cdb1_tag == t) return {cdb1_data, tagFree};
    return {v, t};
  endfunction

  task automatic model_step();
    int sel;
    int fr;
    sel = -1;
    fr  = -1;
    for (int i = 0; i < 8; i++) begin
      if (sel < 0 && m_v[i] && m_t1[i] == tagFree && m_t2[i] == tagFree)
        sel = i;
      if (fr < 0 && !m_v[i]) fr = i;
    end
    if (flush) begin
      for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
      e_en  = 1'b0;
      e_dst = tagFree;
    end else begin
      e_en = (sel >= 0);
      if (sel >= 0) begin
        e_s1  = m_s1[sel];
        e_s2  = m_s2[sel];
        e_pc  = m_pc[sel];
        e_op  = m_op[sel];
        e_dst = m_dst[sel];
        m_v[sel] = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        if (m_v[i]) begin
          {m_s1[i], m_t1[i]} = wake(m_s1[i], m_t1[i]);
          {m_s2[i], m_t2[i]} = wake(m_s2[i], m_t2[i]);
        end
      end
      if (disp_en && fr >= 0) begin
        m_v[fr]   = 1'b1;
        m_op[fr]  = disp_op;
        m_pc[fr]  = disp_pc;
        m_dst[fr] = disp_dest;
        {m_s1[fr], m_t1[fr]} = wake(disp_src1, disp_tag1);
        {m_s2[fr], m_t2[fr]} = wake(disp_src2, disp_tag2);
      end
    end
  endtask

  task automatic test_random();
    int nfull;
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
    e_en = 0; e_s1 = 0; e_s2 = 0; e_pc = 0; e_op = 0; e_dst = tagFree;
    for (int c = 0; c < 600; c++) begin
      nfull = 0;
      for (int i = 0; i < 8; i++) nfull += int'(m_v[i]);
      idle();
      flush     = ($urandom_range(0, 59) == 0);
      disp_en   = (nfull < 8) && ($urandom_range(0, 1) == 1);
      disp_op   = 4'($urandom);
      disp_pc   = $urandom;
      disp_dest = 6'($urandom_range(1, 63));
      disp_src1 = $urandom;
      disp_src2 = $urandom;
      disp_tag1 = ($urandom_range(0, 1) == 1) ? tagFree : 6'($urandom_range(1, 12));
      disp_tag2 = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 12)) : tagFree;
      cdb0_en   = ($urandom_range(0, 2) == 0);
      cdb0_tag  = 6'($urandom_range(1, 12));
      cdb0_data = $urandom;
      cdb1_en   = ($urandom_range(0, 2) == 0);
      cdb1_tag  = 6'($urandom_range(1, 12));
      cdb1_data = $urandom;
      model_step();
      tick();
      nfull = 0;
      for (int i = 0; i < 8; i++) nfull += int'(m_v[i]);
      n_cmp++;
      if ({ex_alu_en, exsrc1, exsrc2, expc, exaluop, exdest}
          !== {e_en, e_s1, e_s2, e_pc, e_op, e_dst}) begin
        n_err++;
        $display("FAIL rand_issue c=%0d: got en=%0b s1=%h s2=%h pc=%h op=%h d=%0d want en=%0b s1=%h s2=%h pc=%h op=%h d=%0d",
                 c, ex_alu_en, exsrc1, exsrc2, expc, exaluop, exdest,
                 e_en, e_s1, e_s2, e_pc, e_op, e_dst);
      end
      n_cmp++;
      if (rs_full !== (nfull == 8)) begin
        n_err++;
        $display("FAIL rand_full c=%0d: full=%0b want %0b", c, rs_full, nfull == 8);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_ready_dispatch();
    test_cdb1_wakeup();
    test_same_cycle_cdb();
    test_full_and_order();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
